// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the fifo write-port arbiter: FSM state encoding and
// a constant-width helper.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Ceiling log2 with a minimum of 1 bit, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if (((value - 1) >> i) != 0) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module fifo_write_arbiter_rr_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PW     = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               any,
    output logic [PW-1:0]      idx
);

    localparam int unsigned SW = PW + 1;

    logic [NUM_REQ-1:0] rot;
    logic [PW-1:0]      off;
    logic [SW-1:0]      sum;

    // Rotate so ptr lands on bit 0, then take the lowest set bit.
    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        any = |rot;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= SW'(NUM_REQ)) begin
            sum = sum - SW'(NUM_REQ);
        end
        idx = sum[PW-1:0];
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the single fifo write port among NUM_REQ
// producers; a grant ends on req_last or after MAX_BURST beats.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned MAX_BURST = 16,
    localparam int unsigned GW       = clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_wr,
    output logic [DATA_SIZE-1:0]           fifo_wdata,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy
);

    localparam int unsigned BW = clog2(MAX_BURST + 1);

    arb_state_e     state_q, state_d;
    logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [BW-1:0]  beat_q, beat_d;

    logic                 pick_any;
    logic [GW-1:0]        pick_idx;
    logic                 sel_valid;
    logic                 sel_last;
    logic [DATA_SIZE-1:0] sel_data;
    logic                 xfer;

    fifo_write_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Per-requester view of the currently granted producer.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            beat_q   <= beat_d;
        end
    end

    // Outputs are combinational from registered state so a reset drops them at once.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_d     = beat_q;
        xfer       = 1'b0;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        req_ready  = '0;
        busy       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                busy       = 1'b1;
                xfer       = sel_valid & ~fifo_full;
                fifo_wr    = xfer;
                fifo_wdata = sel_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == GW'(i)) begin
                        req_ready[i] = ~fifo_full;
                    end
                end
                if (xfer) begin
                    if (sel_last || (beat_q == BW'(MAX_BURST - 1))) begin
                        state_d  = ST_IDLE;
                        beat_d   = '0;
                        rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_id = grant_q;

endmodule
